command_decoder: RTL and testbench

- Front end of the analyzer command path. Receives a SUMP-style byte stream from the UART receiver and frames it into complete commands.
- Short commands are one byte (opcode bit 7 = 0). Long commands are five bytes (opcode bit 7 = 1, then 4 data bytes, LSB first).
- For each complete command it presents opcode/command and a one-cycle cmd_recv_rx strobe to the analyzer controller.

---
 rtl/cmd_pkg.sv | 29 ++
 rtl/command_decoder_if.sv | 30 +++
 rtl/cmd_timeout_counter.sv | 34 +++
 rtl/command_decoder.sv | 138 +++++++++++++
 tb/tb_command_decoder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cmd_pkg
// Shared types and constants for the SUMP command decoder.
// Revision : 1.0
// ============================================================================
package cmd_pkg;

    typedef enum logic [0:0] {
        WAIT_OPCODE = 1'b0,
        WAIT_DATA   = 1'b1
    } decoder_state;

    localparam int         LONG_CMD_BIT    = 7;
    localparam int         LONG_DATA_BYTES = 4;
    localparam logic [1:0] LAST_DATA_IDX   = 2'(LONG_DATA_BYTES - 1);

    localparam logic [7:0] OP_RESET       = 8'h00;
    localparam logic [7:0] OP_ARM         = 8'h01;
    localparam logic [7:0] OP_QUERY_ID    = 8'h02;
    localparam logic [7:0] OP_QUERY_META  = 8'h04;
    localparam logic [7:0] OP_FINISH      = 8'h05;
    localparam logic [7:0] OP_SET_DIVIDER = 8'h80;
    localparam logic [7:0] OP_SET_COUNTS  = 8'h81;
    localparam logic [7:0] OP_TRIG_MASK   = 8'hC0;
    localparam logic [7:0] OP_TRIG_VALUE  = 8'hC1;

endpackage
`default_nettype wire

// File: rtl/command_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : command_decoder_if
// Byte-stream input and framed-command output of the command decoder.
// Revision  : 1.0
// ============================================================================
interface command_decoder_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        cmd_busy;
    logic        timeout_err;

    // Decoder side
    modport master (
        input  rx_data, rx_valid,
        output opcode, command, cmd_recv_rx, cmd_busy, timeout_err
    );

    // UART / controller side
    modport slave (
        output rx_data, rx_valid,
        input  opcode, command, cmd_recv_rx, cmd_busy, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/cmd_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : cmd_timeout_counter
// Counts idle clocks; expire pulses on the clock the count reaches TIMEOUT_CYCLES.
// Revision : 1.0
// ============================================================================
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] c_last_count = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (count) begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

    // Fires on the idle clock whose increment would bring the count to TIMEOUT_CYCLES
    assign expire = count && !clear && (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : command_decoder
// Frames a SUMP byte stream into 1-byte short and 5-byte long commands.
// Optional : CMD_TIMEOUT_EN adds an inter-byte timeout for long commands.
// Revision : 1.0
// ============================================================================
module command_decoder
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    command_decoder_if.master bus
);

    decoder_state r_state,      w_state_nxt;
    logic [1:0]   r_idx,        w_idx_nxt;
    logic [7:0]   r_stage_op,   w_stage_op_nxt;
    logic [23:0]  r_stage_data, w_stage_data_nxt;
    logic [7:0]   r_opcode,     w_opcode_nxt;
    logic [31:0]  r_command,    w_command_nxt;
    logic         r_recv,       w_recv_nxt;
    logic         r_busy;
    logic         r_timeout,    w_timeout_nxt;
    logic         w_timeout;

`ifdef CMD_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_count;

    assign w_tmo_clear = (r_state != WAIT_DATA) || bus.rx_valid;
    assign w_tmo_count = (r_state == WAIT_DATA) && !bus.rx_valid;

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_tmo_clear),
        .count  (w_tmo_count),
        .expire (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= WAIT_OPCODE;
            r_idx        <= 2'd0;
            r_stage_op   <= 8'h00;
            r_stage_data <= 24'h0;
            r_opcode     <= 8'h00;
            r_command    <= 32'h0;
            r_recv       <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_stage_op   <= w_stage_op_nxt;
            r_stage_data <= w_stage_data_nxt;
            r_opcode     <= w_opcode_nxt;
            r_command    <= w_command_nxt;
            r_recv       <= w_recv_nxt;
            r_busy       <= (w_state_nxt == WAIT_DATA);
            r_timeout    <= w_timeout_nxt;
        end
    end

    // Partial long commands live only in the staging registers; the visible
    // opcode/command pair is updated solely together with the strobe.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_stage_op_nxt   = r_stage_op;
        w_stage_data_nxt = r_stage_data;
        w_opcode_nxt     = r_opcode;
        w_command_nxt    = r_command;
        w_recv_nxt       = 1'b0;
        w_timeout_nxt    = 1'b0;

        case (r_state)
            WAIT_OPCODE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[LONG_CMD_BIT]) begin
                        w_stage_op_nxt   = bus.rx_data;
                        w_stage_data_nxt = 24'h0;
                        w_idx_nxt        = 2'd0;
                        w_state_nxt      = WAIT_DATA;
                    end else begin
                        w_opcode_nxt  = bus.rx_data;
                        w_command_nxt = 32'h0;
                        w_recv_nxt    = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                if (bus.rx_valid) begin
                    if (r_idx == LAST_DATA_IDX) begin
                        w_opcode_nxt  = r_stage_op;
                        w_command_nxt = {bus.rx_data, r_stage_data};
                        w_recv_nxt    = 1'b1;
                        w_idx_nxt     = 2'd0;
                        w_state_nxt   = WAIT_OPCODE;
                    end else begin
                        case (r_idx)
                            2'd0:    w_stage_data_nxt[7:0]   = bus.rx_data;
                            2'd1:    w_stage_data_nxt[15:8]  = bus.rx_data;
                            default: w_stage_data_nxt[23:16] = bus.rx_data;
                        endcase
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_idx_nxt     = 2'd0;
                    w_state_nxt   = WAIT_OPCODE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_OPCODE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    assign bus.opcode      = r_opcode;
    assign bus.command     = r_command;
    assign bus.cmd_recv_rx = r_recv;
    assign bus.cmd_busy    = r_busy;
    assign bus.timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_command_decoder
// Directed self-checking bench for command_decoder (timeout cases under CMD_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module tb_command_decoder;
    import cmd_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    command_decoder_if bus ();

    command_decoder #(
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Event monitor, sampled 1 time unit after each rising edge
    int         n_strobe = 0;
    int         n_terr   = 0;
    int         n_busy   = 0;
    logic [7:0] last_op  = 8'hEE;

    always @(posedge clock) begin
        #1;
        if (bus.cmd_recv_rx) begin
            n_strobe <= n_strobe + 1;
            last_op  <= bus.opcode;
        end
        if (bus.timeout_err) n_terr <= n_terr + 1;
        if (bus.cmd_busy)    n_busy <= n_busy + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'h00;
        end
    endtask

    int base_s;
    int base_t;
    int base_b;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        idle(3);
        check_eq("rst_opcode",  32'(bus.opcode), 32'h00);
        check_eq("rst_command", bus.command, 32'h0);
        check_eq("rst_recv",    32'(bus.cmd_recv_rx), 32'd0);
        check_eq("rst_busy",    32'(bus.cmd_busy), 32'd0);
        check_eq("rst_terr",    32'(bus.timeout_err), 32'd0);
        reset = 1'b0;
        idle(2);

        // Short command
        base_s = n_strobe;
        base_b = n_busy;
        drive(OP_QUERY_ID);
        idle(1);
        check_eq("short_recv",    32'(bus.cmd_recv_rx), 32'd1);
        check_eq("short_opcode",  32'(bus.opcode), 32'h02);
        check_eq("short_command", bus.command, 32'h0);
        idle(1);
        check_eq("short_recv_1cyc", 32'(bus.cmd_recv_rx), 32'd0);
        idle(2);
        check_eq("short_count", 32'(n_strobe - base_s), 32'd1);
        check_eq("short_busy",  32'(n_busy - base_b), 32'd0);

        // Long command, bytes spaced 10 cycles
        base_s = n_strobe;
        drive(OP_SET_COUNTS);
        idle(1);
        check_eq("long_busy_on",  32'(bus.cmd_busy), 32'd1);
        check_eq("long_hold_op",  32'(bus.opcode), 32'h02);
        idle(8);
        drive(8'h10); idle(9);
        drive(8'h20); idle(9);
        drive(8'h30); idle(9);
        check_eq("long_hold_op2",  32'(bus.opcode), 32'h02);
        check_eq("long_hold_cmd",  bus.command, 32'h0);
        check_eq("long_busy_mid",  32'(bus.cmd_busy), 32'd1);
        check_eq("long_no_strobe", 32'(n_strobe - base_s), 32'd0);
        drive(8'h40);
        idle(1);
        check_eq("long_recv",    32'(bus.cmd_recv_rx), 32'd1);
        check_eq("long_opcode",  32'(bus.opcode), 32'h81);
        check_eq("long_command", bus.command, 32'h40302010);
        check_eq("long_busy_off", 32'(bus.cmd_busy), 32'd0);
        idle(3);
        check_eq("long_hold_after", bus.command, 32'h40302010);
        check_eq("long_count", 32'(n_strobe - base_s), 32'd1);

        // Back-to-back long then short
        base_s = n_strobe;
        drive(OP_TRIG_MASK);
        drive(8'hFF);
        drive(8'h00);
        drive(8'h00);
        drive(8'h00);
        drive(OP_ARM);
        check_eq("b2b_recv1",    32'(bus.cmd_recv_rx), 32'd1);
        check_eq("b2b_opcode1",  32'(bus.opcode), 32'hC0);
        check_eq("b2b_command1", bus.command, 32'h000000FF);
        idle(1);
        check_eq("b2b_recv2",    32'(bus.cmd_recv_rx), 32'd1);
        check_eq("b2b_opcode2",  32'(bus.opcode), 32'h01);
        check_eq("b2b_command2", bus.command, 32'h0);
        idle(2);
        check_eq("b2b_count", 32'(n_strobe - base_s), 32'd2);

        // Reset in the middle of a long command
        base_s = n_strobe;
        drive(OP_SET_DIVIDER);
        drive(8'hAA);
        @(negedge clock);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_eq("mrst_opcode",  32'(bus.opcode), 32'h00);
        check_eq("mrst_command", bus.command, 32'h0);
        check_eq("mrst_busy",    32'(bus.cmd_busy), 32'd0);
        check_eq("mrst_recv",    32'(bus.cmd_recv_rx), 32'd0);
        reset = 1'b0;
        idle(2);
        check_eq("mrst_busy_after", 32'(bus.cmd_busy), 32'd0);
        check_eq("mrst_no_strobe",  32'(n_strobe - base_s), 32'd0);
        drive(OP_RESET);
        idle(1);
        check_eq("mrst_recv_new",   32'(bus.cmd_recv_rx), 32'd1);
        check_eq("mrst_opcode_new", 32'(bus.opcode), 32'h00);
        check_eq("mrst_cmd_new",    bus.command, 32'h0);
        idle(2);
        check_eq("mrst_count", 32'(n_strobe - base_s), 32'd1);

        // SUMP reset: five zero bytes
        base_s = n_strobe;
        base_b = n_busy;
        repeat (5) drive(OP_RESET);
        idle(3);
        check_eq("sump_count",   32'(n_strobe - base_s), 32'd5);
        check_eq("sump_last_op", 32'(last_op), 32'h00);
        check_eq("sump_busy",    32'(n_busy - base_b), 32'd0);

`ifdef CMD_TIMEOUT_EN
        // Partial command abandoned after 50 idle clocks
        base_s = n_strobe;
        base_t = n_terr;
        drive(OP_TRIG_VALUE);
        drive(8'h05);
        idle(50);
        check_eq("tmo_busy_before", 32'(bus.cmd_busy), 32'd1);
        check_eq("tmo_terr_before", 32'(bus.timeout_err), 32'd0);
        idle(1);
        check_eq("tmo_terr",     32'(bus.timeout_err), 32'd1);
        check_eq("tmo_busy_off", 32'(bus.cmd_busy), 32'd0);
        check_eq("tmo_no_recv",  32'(bus.cmd_recv_rx), 32'd0);
        check_eq("tmo_hold_op",  32'(bus.opcode), 32'h00);
        idle(1);
        check_eq("tmo_terr_1cyc", 32'(bus.timeout_err), 32'd0);
        drive(OP_ARM);
        idle(1);
        check_eq("tmo_next_recv",   32'(bus.cmd_recv_rx), 32'd1);
        check_eq("tmo_next_opcode", 32'(bus.opcode), 32'h01);
        idle(2);
        check_eq("tmo_count", 32'(n_strobe - base_s), 32'd1);
        check_eq("tmo_terr_count", 32'(n_terr - base_t), 32'd1);

        // Byte arriving on the 50th idle clock wins over the timeout
        base_t = n_terr;
        drive(OP_TRIG_VALUE);
        drive(8'h05);
        idle(49);
        drive(8'h06);
        idle(5);
        check_eq("edge_no_terr", 32'(n_terr - base_t), 32'd0);
        check_eq("edge_busy",    32'(bus.cmd_busy), 32'd1);
        drive(8'h07);
        drive(8'h08);
        idle(1);
        check_eq("edge_recv",    32'(bus.cmd_recv_rx), 32'd1);
        check_eq("edge_opcode",  32'(bus.opcode), 32'hC1);
        check_eq("edge_command", bus.command, 32'h08070605);
`else
        // Without the timeout a partial command waits indefinitely
        base_t = n_terr;
        drive(OP_TRIG_VALUE);
        drive(8'h05);
        idle(80);
        check_eq("notmo_busy", 32'(bus.cmd_busy), 32'd1);
        check_eq("notmo_terr", 32'(n_terr - base_t), 32'd0);
        drive(8'h06);
        drive(8'h07);
        drive(8'h08);
        idle(1);
        check_eq("notmo_opcode",  32'(bus.opcode), 32'hC1);
        check_eq("notmo_command", bus.command, 32'h08070605);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
